// File: rtl/cursor_move_ctrl_if.sv
// Bundle between the direction-button front end and the board-position register.
// Latency: none, wires only.
// Backpressure: none; the position register takes the move strobes as they come.
//
// Signals:
//   btn_n      raw active-low buttons (bit0 up, bit1 down, bit2 left, bit3 right)
//   enable     moves accepted only while high
//   i_actual   committed row from the position register
//   j_actual   committed column from the position register
//   i_next     proposed row
//   j_next     proposed column
//   move_pulse one-cycle strobe marking a new proposal
//   blocked    one-cycle strobe marking a move refused at a board edge
// The master drives the buttons and the committed position. The slave is the cursor
// controller.
interface cursor_move_ctrl_if;
    logic [3:0] btn_n;
    logic       enable;
    logic [2:0] i_actual;
    logic [2:0] j_actual;
    logic [2:0] i_next;
    logic [2:0] j_next;
    logic       move_pulse;
    logic       blocked;

    modport master (
        output btn_n, enable, i_actual, j_actual,
        input  i_next, j_next, move_pulse, blocked
    );

    modport slave (
        input  btn_n, enable, i_actual, j_actual,
        output i_next, j_next, move_pulse, blocked
    );
endinterface

// File: rtl/cursor_move_ctrl.sv
// Cursor move controller: sync + debounce four buttons, one move per press plus auto-repeat.
// Latency: a move appears DEBOUNCE_CYCLES+2 posedges after btn_n falls. Outputs are registered.
// Backpressure: none; the position register must commit i_next/j_next on the negedge after move_pulse.
//
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   bus.slave  button inputs, enable, and committed position in
//              proposed position and strobes out
module cursor_move_ctrl #(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int WRAP            = 1
) (
    input  logic               clk,
    input  logic               rst,
    cursor_move_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, QUALIFY, HELD, RELEASE} state_t;

    localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST  = 32'(REPEAT_PERIOD - 1);
    localparam logic [2:0]  I_MAX    = 3'(ROWS - 1);
    localparam logic [2:0]  J_MAX    = 3'(COLS - 1);

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  btn;
    state_t      state;
    logic [31:0] cnt;
    logic [3:0]  dir;
    logic        rep;        // set once the first auto-repeat has fired
    logic        fire;
    logic        attempt;
    logic [2:0]  i_mv;
    logic [2:0]  j_mv;
    logic        edge_hit;

    assign btn = ~sync2;

    // A move fires on the last qualify cycle, and in HELD on the repeat schedule.
    always_comb begin
        fire = 1'b0;
        case (state)
            QUALIFY: fire = (btn == dir) && (cnt == DEB_LAST);
            HELD:    fire = (btn == dir) && (REPEAT_DELAY != 0) &&
                            (rep ? (cnt == RP_LAST) : (cnt == RD_LAST));
            default: fire = 1'b0;
        endcase
    end

    // A fired move is dropped silently when disabled or when dir holds several buttons.
    assign attempt = fire && bus.enable && $onehot(dir);

    // Neighbour cell from the committed position. edge_hit only rises in clamp mode.
    always_comb begin
        i_mv     = bus.i_actual;
        j_mv     = bus.j_actual;
        edge_hit = 1'b0;
        case (dir)
            4'b0001: begin
                if (bus.i_actual == 3'd0) begin
                    if (WRAP != 0) i_mv = I_MAX;
                    else           edge_hit = 1'b1;
                end else begin
                    i_mv = bus.i_actual - 3'd1;
                end
            end
            4'b0010: begin
                if (bus.i_actual == I_MAX) begin
                    if (WRAP != 0) i_mv = 3'd0;
                    else           edge_hit = 1'b1;
                end else begin
                    i_mv = bus.i_actual + 3'd1;
                end
            end
            4'b0100: begin
                if (bus.j_actual == 3'd0) begin
                    if (WRAP != 0) j_mv = J_MAX;
                    else           edge_hit = 1'b1;
                end else begin
                    j_mv = bus.j_actual - 3'd1;
                end
            end
            4'b1000: begin
                if (bus.j_actual == J_MAX) begin
                    if (WRAP != 0) j_mv = 3'd0;
                    else           edge_hit = 1'b1;
                end else begin
                    j_mv = bus.j_actual + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1          <= 4'hF;
            sync2          <= 4'hF;
            state          <= IDLE;
            cnt            <= 32'd0;
            dir            <= 4'd0;
            rep            <= 1'b0;
            bus.i_next     <= 3'd0;
            bus.j_next     <= 3'd0;
            bus.move_pulse <= 1'b0;
            bus.blocked    <= 1'b0;
        end else begin
            sync1 <= bus.btn_n;
            sync2 <= sync1;

            // Track the committed cell so a stale proposal is never re-committed.
            bus.i_next     <= bus.i_actual;
            bus.j_next     <= bus.j_actual;
            bus.move_pulse <= 1'b0;
            bus.blocked    <= 1'b0;
            if (attempt) begin
                if (edge_hit) begin
                    bus.blocked <= 1'b1;
                end else begin
                    bus.i_next     <= i_mv;
                    bus.j_next     <= j_mv;
                    bus.move_pulse <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (btn != 4'd0) begin
                        dir   <= btn;
                        cnt   <= 32'd0;
                        state <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (btn != dir) begin
                        state <= IDLE;
                    end else if (fire) begin
                        cnt   <= 32'd0;
                        rep   <= 1'b0;
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HELD: begin
                    if (btn != dir) begin
                        cnt   <= 32'd0;
                        state <= RELEASE;
                    end else if (REPEAT_DELAY != 0) begin
                        if (fire) begin
                            cnt <= 32'd0;
                            rep <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                RELEASE: begin
                    // Any activity restarts the release window.
                    if (btn != 4'd0)          cnt   <= 32'd0;
                    else if (cnt == DEB_LAST) state <= IDLE;
                    else                      cnt   <= cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl. Two instances share the stimulus.
// Instance 0: wrap mode, auto-repeat with delay 10 and period 3.
// Instance 1: clamp mode, no auto-repeat.
// A reference model predicts all outputs of both instances every cycle.
module tb_cursor_move_ctrl;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cursor_move_ctrl_if bus0();
    cursor_move_ctrl_if bus1();

    cursor_move_ctrl #(.ROWS(8), .COLS(8), .DEBOUNCE_CYCLES(DEB),
                       .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .WRAP(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    cursor_move_ctrl #(.ROWS(8), .COLS(8), .DEBOUNCE_CYCLES(DEB),
                       .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .WRAP(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic [3:0] btn_n  = 4'hF;
    logic       enable = 1'b1;
    logic [2:0] i_act  = 3'd0;
    logic [2:0] j_act  = 3'd0;
    bit         commit_en = 1'b0;

    assign bus0.btn_n = btn_n;  assign bus1.btn_n = btn_n;
    assign bus0.enable = enable; assign bus1.enable = enable;
    assign bus0.i_actual = i_act; assign bus1.i_actual = i_act;
    assign bus0.j_actual = j_act; assign bus1.j_actual = j_act;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int         cyc = 0;
    logic [3:0] s1 = 4'hF;
    logic [3:0] s2 = 4'hF;
    int         mode [2];  // 0 waiting, 1 qualifying, 2 held, 3 releasing
    int         age  [2];
    int         hold [2];
    int         zeros[2];
    logic [3:0] d    [2];
    logic [2:0] exp_i[2];
    logic [2:0] exp_j[2];
    logic       exp_mp[2];
    logic       exp_bl[2];
    int         n_mv[2];
    int         n_bl[2];
    int         mv_cyc[$];
    int         mv_i[$];
    int         mv_j[$];

    function automatic int rd_of(int k); return (k == 0) ? 10 : 0; endfunction
    function automatic int rp_of(int k); return (k == 0) ? 3 : 1; endfunction

    task automatic model_reset();
        s1 = 4'hF; s2 = 4'hF;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; age[k] = 0; hold[k] = 0; zeros[k] = 0; d[k] = 4'd0;
            exp_i[k] = 3'd0; exp_j[k] = 3'd0; exp_mp[k] = 1'b0; exp_bl[k] = 1'b0;
        end
    endtask

    task automatic apply_move(int k);
        int ni;
        int nj;
        ni = int'(i_act);
        nj = int'(j_act);
        case (d[k])
            4'b0001: ni = ni - 1;
            4'b0010: ni = ni + 1;
            4'b0100: nj = nj - 1;
            default: nj = nj + 1;
        endcase
        if (ni < 0 || ni > 7 || nj < 0 || nj > 7) begin
            if (k == 0) begin
                ni = (ni + 8) % 8;
                nj = (nj + 8) % 8;
            end else begin
                exp_bl[k] = 1'b1;
                n_bl[k]++;
                return;
            end
        end
        exp_i[k]  = 3'(ni);
        exp_j[k]  = 3'(nj);
        exp_mp[k] = 1'b1;
        n_mv[k]++;
        if (k == 0) begin
            mv_cyc.push_back(cyc); mv_i.push_back(ni); mv_j.push_back(nj);
        end
    endtask

    task automatic model_step();
        logic [3:0] b;
        bit         att;
        b  = ~s2;
        s2 = s1;
        s1 = btn_n;
        for (int k = 0; k < 2; k++) begin
            att = 1'b0;
            exp_i[k] = i_act; exp_j[k] = j_act; exp_mp[k] = 1'b0; exp_bl[k] = 1'b0;
            case (mode[k])
                0: if (b != 4'd0) begin mode[k] = 1; d[k] = b; age[k] = 1; end
                1: begin
                    if (b != d[k]) mode[k] = 0;
                    else begin
                        age[k]++;
                        if (age[k] == DEB + 1) begin att = 1'b1; mode[k] = 2; hold[k] = 0; end
                    end
                end
                2: begin
                    if (b != d[k]) begin mode[k] = 3; zeros[k] = 0; end
                    else begin
                        hold[k]++;
                        if (rd_of(k) != 0 && hold[k] >= rd_of(k) &&
                            (hold[k] - rd_of(k)) % rp_of(k) == 0) att = 1'b1;
                    end
                end
                default: begin
                    if (b != 4'd0) zeros[k] = 0;
                    else begin
                        zeros[k]++;
                        if (zeros[k] == DEB) mode[k] = 0;
                    end
                end
            endcase
            if (att && enable && $onehot(d[k])) apply_move(k);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else begin
                cyc++;
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [2:0] ai, aj;
                logic       am, ab;
                ai = (k == 0) ? bus0.i_next : bus1.i_next;
                aj = (k == 0) ? bus0.j_next : bus1.j_next;
                am = (k == 0) ? bus0.move_pulse : bus1.move_pulse;
                ab = (k == 0) ? bus0.blocked : bus1.blocked;
                n_chk++;
                if (ai !== exp_i[k] || aj !== exp_j[k] || am !== exp_mp[k] || ab !== exp_bl[k]) begin
                    n_fail++;
                    $display("FAIL outputs dut%0d cyc %0d: got i=%0d j=%0d mp=%0d bl=%0d, want i=%0d j=%0d mp=%0d bl=%0d",
                             k, cyc, ai, aj, am, ab, exp_i[k], exp_j[k], exp_mp[k], exp_bl[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(string name, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (commit_en && exp_mp[0] === 1'b1) begin
                i_act = exp_i[0];
                j_act = exp_j[0];
            end
        end
    endtask

    task automatic clear_log();
        mv_cyc.delete(); mv_i.delete(); mv_j.delete();
        n_mv[0] = 0; n_mv[1] = 0; n_bl[0] = 0; n_bl[1] = 0;
    endtask

    // Press, hold, release, and wait until both instances are back to waiting.
    task automatic press(logic [3:0] v, int hold_cycles, output int p);
        btn_n = ~v;
        p = cyc + 1;
        tick(hold_cycles);
        btn_n = 4'hF;
        tick(10);
    endtask

    initial begin
        int p;
        int q;
        int offs[6];
        offs = '{6, 16, 19, 22, 25, 28};

        i_act = 3'd5; j_act = 3'd6;
        tick(3);
        chk("reset i_next", int'(bus0.i_next), 0);
        chk("reset move_pulse", int'(bus1.move_pulse), 0);
        rst = 1'b1;
        tick(3);

        // Clean right press from (3,3)
        i_act = 3'd3; j_act = 3'd3; tick(2); clear_log();
        press(4'b1000, 10, p);
        chk("clean moves", n_mv[0], 1);
        chk("clean latency", mv_cyc[0] - p, 6);
        chk("clean j_next", mv_j[0], 4);
        chk("clean i_next", mv_i[0], 3);
        chk("clean clamp-dut moves", n_mv[1], 1);

        // Bouncing down press, then stable
        clear_log();
        repeat (3) begin
            btn_n = 4'b1101; tick(2);
            btn_n = 4'hF;    tick(2);
        end
        chk("bounce no move", n_mv[0] + n_mv[1], 0);
        press(4'b0010, 10, p);
        chk("bounce moves", n_mv[0], 1);
        chk("bounce latency", mv_cyc[0] - p, 6);
        chk("bounce i_next", mv_i[0], 4);

        // Wrap vs clamp at (0,7)
        i_act = 3'd0; j_act = 3'd7; tick(2); clear_log();
        press(4'b0001, 10, p);
        chk("wrap up i_next", mv_i[0], 7);
        chk("clamp up blocked", n_bl[1], 1);
        chk("clamp up no move", n_mv[1], 0);
        clear_log();
        press(4'b1000, 10, p);
        chk("wrap right j_next", mv_j[0], 0);
        chk("clamp right blocked", n_bl[1], 1);

        // Clamp left at (0,0)
        i_act = 3'd0; j_act = 3'd0; tick(2); clear_log();
        press(4'b0100, 10, p);
        chk("clamp left blocked", n_bl[1], 1);
        chk("clamp left no move", n_mv[1], 0);
        chk("wrap left j_next", mv_j[0], 7);

        // Auto-repeat from (7,2) with commits
        i_act = 3'd7; j_act = 3'd2; tick(2); clear_log();
        commit_en = 1'b1;
        press(4'b0001, 29, p);
        commit_en = 1'b0;
        chk("repeat count", n_mv[0], 6);
        for (int m = 0; m < 6; m++) begin
            chk($sformatf("repeat %0d time", m), mv_cyc[m] - p, offs[m]);
            chk($sformatf("repeat %0d i_next", m), mv_i[m], 6 - m);
        end

        // Two buttons together
        i_act = 3'd4; j_act = 3'd4; tick(2); clear_log();
        press(4'b0101, 10, p);
        chk("two buttons no move", n_mv[0] + n_mv[1] + n_bl[1], 0);

        // Disabled at firing edge, enabled later while still held
        clear_log();
        enable = 1'b0;
        btn_n = 4'b0111;
        tick(8);
        enable = 1'b1;
        tick(4);
        btn_n = 4'hF;
        tick(10);
        chk("disabled no move", n_mv[0] + n_mv[1], 0);

        // Reset during qualification
        i_act = 3'd3; j_act = 3'd3; tick(2); clear_log();
        btn_n = 4'b0111;
        tick(4);
        rst = 1'b0;
        #1;
        chk("mid reset i_next", int'(bus0.i_next), 0);
        chk("mid reset j_next", int'(bus1.j_next), 0);
        tick(2);
        rst = 1'b1;
        q = cyc + 1;
        tick(12);
        btn_n = 4'hF;
        tick(10);
        chk("post reset moves", n_mv[0], 1);
        chk("post reset latency", mv_cyc[0] - q, 6);
        chk("post reset j_next", mv_j[0], 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
